modexp_ctrl: RTL and testbench

- Sequencer for left-to-right square-and-multiply modular exponentiation on one shared Montgomery-product (MonPro) engine.
- Scans exponent bits from exponent word memory and issues an ordered list of MonPro operations over a start/done handshake.
- Tags each operation with an opcode; the engine-side operand mux uses the tag to pick operand/result registers.
- Sits between the top-level RSA control and the MonPro engine. Carries no multi-precision data itself.

---
 rtl/modexp_pkg.sv | 51 +++++
 rtl/modexp_ctrl_exp_bit_fetcher.sv | 62 ++++++
 rtl/modexp_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_modexp_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// -----------------------------------------------------------------------------
// modexp_pkg
// Shared definitions for the modular-exponentiation sequencer:
//   - MonPro opcode constants issued on mp_op
//   - controller state encoding
//   - default exponent-memory geometry and the widths derived from it
//   - small helper for the saturating operation counter
// -----------------------------------------------------------------------------
package modexp_pkg;

  // Default exponent memory geometry: TOTAL_ADDR words of DATA_WIDTH bits.
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_TOTAL_ADDR = 128;

  // Word address width and bit-count width (bit count must hold the full
  // DATA_WIDTH*TOTAL_ADDR value, hence the +1).
  localparam int unsigned DEF_AW  = $clog2(DEF_TOTAL_ADDR);
  localparam int unsigned DEF_EBW = $clog2(DEF_DATA_WIDTH * DEF_TOTAL_ADDR) + 1;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned CNT_W = 16;

  typedef logic [OP_W-1:0] op_t;

  // MonPro operation tags; the engine-side operand mux decodes these.
  localparam op_t OP_MONT_M   = 3'd0;  // Mbar   = MonPro(M, R2)
  localparam op_t OP_MONT_ONE = 3'd1;  // A      = MonPro(1, R2)
  localparam op_t OP_SQR      = 3'd2;  // A      = MonPro(A, A)
  localparam op_t OP_MUL      = 3'd3;  // A      = MonPro(A, Mbar)
  localparam op_t OP_FINAL    = 3'd4;  // result = MonPro(A, 1)
  // 5..7 are reserved and never issued.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_FETCH = 3'd3,
    S_LOAD  = 3'd4,
    S_SCAN  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/modexp_ctrl_exp_bit_fetcher.sv
// -----------------------------------------------------------------------------
// exp_bit_fetcher
// Owns the exponent-word read cycle and the current-word register.
// The controller points it at a bit index; it drives the word read during
// FETCH, captures the returned word during LOAD, and hands back the selected
// exponent bit plus a flag saying the next decrement leaves the current word.
//
// Ports:
//   clk              clock
//   fetch_i          controller is in FETCH (issue the read this cycle)
//   load_i           controller is in LOAD (read data is valid this cycle)
//   bit_idx_i        current exponent bit index
//   exp_word_i       exponent memory read data (valid the cycle after exp_rd_o)
//   exp_rd_o         exponent word read strobe
//   exp_addr_o       exponent word address (word holding bit_idx_i)
//   bit_o            exponent bit at bit_idx_i within the held word
//   word_crossing_o  bit_idx_i sits at bit 0 of its word, so bit_idx_i-1
//                    lives in the next-lower word
// -----------------------------------------------------------------------------
module exp_bit_fetcher #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned AW         = 7,
  parameter int unsigned EBW        = 13
) (
  input  logic                  clk,
  input  logic                  fetch_i,
  input  logic                  load_i,
  input  logic [EBW-1:0]        bit_idx_i,
  input  logic [DATA_WIDTH-1:0] exp_word_i,
  output logic                  exp_rd_o,
  output logic [AW-1:0]         exp_addr_o,
  output logic                  bit_o,
  output logic                  word_crossing_o
);

  localparam int unsigned LDW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] word_q, word_d;

  // The word register is pure data: it is always reloaded before use, so it
  // carries no reset.
  always_comb begin
    word_d = word_q;
    if (load_i) begin
      word_d = exp_word_i;
    end
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign exp_rd_o        = fetch_i;
  assign exp_addr_o      = bit_idx_i[LDW +: AW];
  assign bit_o           = word_q[bit_idx_i[LDW-1:0]];
  assign word_crossing_o = (bit_idx_i[LDW-1:0] == '0);

  // The top bit of the index only matters for the bit count, not addressing.
  logic unused_idx_bits;
  assign unused_idx_bits = ^bit_idx_i;

endmodule

// File: rtl/modexp_ctrl.sv
// -----------------------------------------------------------------------------
// modexp_ctrl
// Sequencer for left-to-right square-and-multiply modular exponentiation on a
// single shared Montgomery-product engine. It walks the exponent from bit
// nb-1 down to bit 0 and issues the MonPro operation list
//   MONT_M, MONT_ONE, { SQR [, MUL if bit=1] } per bit, FINAL
// over a start/done handshake. No multi-precision data passes through here.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   start      exponentiation request, sampled only in IDLE
//   exp_nbits  exponent bit length, sampled with start (clamped to memory size)
//   exp_rd     exponent word read strobe
//   exp_addr   exponent word address
//   exp_word   exponent read data, valid the cycle after exp_rd
//   mp_start   one-cycle MonPro launch pulse
//   mp_op      MonPro opcode, stable from mp_start until mp_done
//   mp_done    one-cycle MonPro completion pulse
//   busy       high from the cycle after start is accepted until done
//   done       one-cycle pulse: result register holds M^E mod N
//   op_count   operations issued in the current/last run (saturating)
// -----------------------------------------------------------------------------
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned TOTAL_ADDR = DEF_TOTAL_ADDR,
  parameter int unsigned AW         = DEF_AW,
  parameter int unsigned EBW        = DEF_EBW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [EBW-1:0]        exp_nbits,
  output logic                  exp_rd,
  output logic [AW-1:0]         exp_addr,
  input  logic [DATA_WIDTH-1:0] exp_word,
  output logic                  mp_start,
  output logic [OP_W-1:0]       mp_op,
  input  logic                  mp_done,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      op_count
);

  localparam logic [EBW-1:0] MAX_BITS = EBW'(DATA_WIDTH * TOTAL_ADDR);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [EBW-1:0]   nb_q, nb_d;
  logic [EBW-1:0]   bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [EBW-1:0]   nb_clamped;
  logic             cur_bit;
  logic             word_crossing;

  assign nb_clamped = (exp_nbits > MAX_BITS) ? MAX_BITS : exp_nbits;

  exp_bit_fetcher #(
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW),
    .EBW        (EBW)
  ) u_fetch (
    .clk             (clk),
    .fetch_i         (state_q == S_FETCH),
    .load_i          (state_q == S_LOAD),
    .bit_idx_i       (bit_idx_q),
    .exp_word_i      (exp_word),
    .exp_rd_o        (exp_rd),
    .exp_addr_o      (exp_addr),
    .bit_o           (cur_bit),
    .word_crossing_o (word_crossing)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_MONT_M;
      nb_q       <= '0;
      bit_idx_q  <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      nb_q       <= nb_d;
      bit_idx_q  <= bit_idx_d;
      op_count_q <= op_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    nb_d       = nb_q;
    bit_idx_d  = bit_idx_q;
    op_count_d = op_count_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          nb_d       = nb_clamped;
          // nb=0 never scans, so the index value is irrelevant there.
          bit_idx_d  = (nb_clamped == '0) ? '0 : (nb_clamped - EBW'(1));
          op_count_d = '0;
          op_d       = OP_MONT_M;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        op_count_d = sat_inc(op_count_q);
        state_d    = S_WAIT;
      end

      // mp_done is only honoured here; a stray pulse elsewhere has no effect.
      S_WAIT: begin
        if (mp_done) begin
          case (op_q)
            OP_MONT_M: begin
              op_d    = OP_MONT_ONE;
              state_d = S_ISSUE;
            end
            OP_MONT_ONE: begin
              if (nb_q == '0) begin
                op_d    = OP_FINAL;
                state_d = S_ISSUE;
              end else begin
                // First word of the exponent has not been read yet.
                state_d = S_FETCH;
              end
            end
            OP_SQR: begin
              if (cur_bit) begin
                op_d    = OP_MUL;
                state_d = S_ISSUE;
              end else begin
                state_d = S_SCAN;
              end
            end
            OP_MUL:   state_d = S_SCAN;
            OP_FINAL: state_d = S_DONE;
            default:  state_d = S_IDLE;
          endcase
        end
      end

      S_SCAN: begin
        if (bit_idx_q == '0) begin
          op_d    = OP_FINAL;
          state_d = S_ISSUE;
        end else begin
          bit_idx_d = bit_idx_q - EBW'(1);
          // Leaving bit 0 of the held word: the next bit needs a fresh word.
          if (word_crossing) begin
            state_d = S_FETCH;
          end else begin
            op_d    = OP_SQR;
            state_d = S_ISSUE;
          end
        end
      end

      S_FETCH: state_d = S_LOAD;

      S_LOAD: begin
        op_d    = OP_SQR;
        state_d = S_ISSUE;
      end

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign mp_start = (state_q == S_ISSUE);
  assign mp_op    = op_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);
  assign op_count = op_count_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
`timescale 1ns/1ps
module tb_modexp_ctrl;

  localparam int DW   = 32;
  localparam int TA   = 128;
  localparam int AWL  = 7;
  localparam int EBWL = 13;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [EBWL-1:0] exp_nbits;
  logic            exp_rd;
  logic [AWL-1:0]  exp_addr;
  logic [DW-1:0]   exp_word = '0;
  logic            mp_start;
  logic [2:0]      mp_op;
  logic            mp_done;
  logic            eng_done = 1'b0;
  logic            spur_done;
  logic            busy;
  logic            done;
  logic [15:0]     op_count;

  assign mp_done = eng_done | spur_done;

  always #5 clk = ~clk;

  modexp_ctrl #(
    .DATA_WIDTH (DW),
    .TOTAL_ADDR (TA),
    .AW         (AWL),
    .EBW        (EBWL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .exp_nbits (exp_nbits),
    .exp_rd    (exp_rd),
    .exp_addr  (exp_addr),
    .exp_word  (exp_word),
    .mp_start  (mp_start),
    .mp_op     (mp_op),
    .mp_done   (mp_done),
    .busy      (busy),
    .done      (done),
    .op_count  (op_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Exponent memory and engine/monitor model, all evaluated on the falling edge.
  logic [DW-1:0] mem [TA];
  int   cyc = 0;
  int   eng_cnt = 0;
  int   eng_lat = 3;
  logic [2:0] cur_op = 3'd0;
  int   ops[$];
  int   rd_addrs[$];
  int   last_done_cyc = 0;
  int   done_cyc = 0;
  int   n_done = 0;
  int   gap4 = 0;
  int   stable_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    eng_done = 1'b0;
    if (eng_cnt > 0) begin
      if (mp_op !== cur_op) stable_err++;
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_done = 1'b1;
        last_done_cyc = cyc;
      end
    end
    if (mp_start) begin
      ops.push_back(int'(mp_op));
      cur_op = mp_op;
      eng_cnt = eng_lat;
      if (cyc - last_done_cyc == 4) gap4++;
    end
    if (exp_rd) begin
      rd_addrs.push_back(int'(exp_addr));
      exp_word = mem[exp_addr];
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  int base_ops, base_rd, base_done, base_gap4, base_stab;

  task automatic take_base();
    base_ops  = ops.size();
    base_rd   = rd_addrs.size();
    base_done = n_done;
    base_gap4 = gap4;
    base_stab = stable_err;
  endtask

  // One full exponentiation; optionally pokes a stray mp_done while in ISSUE
  // and a stray start while in WAIT.
  task automatic run_exp(input string tag, input int nb, input bit poke);
    repeat (8) @(negedge clk);
    take_base();
    exp_nbits = EBWL'(nb);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_eq({tag, "_busy_after_start"}, busy, 1);
    if (poke) begin
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      exp_nbits = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 5000 && !done; i++) @(negedge clk);
    chk_eq({tag, "_done_seen"}, done, 1);
    chk_eq({tag, "_busy_at_done"}, busy, 0);
    repeat (3) @(negedge clk);
    chk_eq({tag, "_one_done"}, n_done - base_done, 1);
    chk_eq({tag, "_op_stable"}, stable_err - base_stab, 0);
  endtask

  // Expected op list packed one nibble per op, first op in the top nibble.
  task automatic chk_ops(input string tag, input logic [255:0] seq, input int n);
    chk_eq({tag, "_nops"}, ops.size() - base_ops, n);
    for (int i = 0; i < n; i++) begin
      if (base_ops + i < ops.size())
        chk_eq($sformatf("%s_op%0d", tag, i), ops[base_ops + i], int'(seq[(n-1-i)*4 +: 4]));
    end
  endtask

  logic [255:0] seq;

  initial begin
    for (int i = 0; i < TA; i++) mem[i] = '0;
    reset = 1'b1;
    start = 1'b0;
    spur_done = 1'b0;
    exp_nbits = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_mp_start", mp_start, 0);
    chk_eq("rst_exp_rd", exp_rd, 0);
    chk_eq("rst_mp_op", mp_op, 0);
    chk_eq("rst_exp_addr", exp_addr, 0);
    chk_eq("rst_op_count", op_count, 0);

    // Stray mp_done while idle.
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    chk_eq("idle_spur_busy", busy, 0);
    chk_eq("idle_spur_mp_start", mp_start, 0);
    chk_eq("idle_spur_op_count", op_count, 0);

    // nb=4, exponent 1011, with stray mp_done in ISSUE and start in WAIT.
    mem[0] = 32'h0000_000B;
    run_exp("nb4", 4, 1'b1);
    chk_ops("nb4", 256'h0123223234, 10);
    chk_eq("nb4_op_count", op_count, 10);
    chk_eq("nb4_nreads", rd_addrs.size() - base_rd, 1);
    if (rd_addrs.size() > base_rd) chk_eq("nb4_rd_addr", rd_addrs[base_rd], 0);

    // nb=0: no scanning at all.
    run_exp("nb0", 0, 1'b0);
    chk_ops("nb0", 256'h014, 3);
    chk_eq("nb0_op_count", op_count, 3);
    chk_eq("nb0_nreads", rd_addrs.size() - base_rd, 0);
    chk_eq("nb0_done_lat", done_cyc - last_done_cyc, 1);

    // nb=34 crosses from word 1 into word 0 between bit 32 and bit 31.
    mem[1] = 32'h0000_0002;
    mem[0] = 32'h8000_0000;
    run_exp("nb34", 34, 1'b0);
    seq = 256'h0123223;
    for (int i = 0; i < 31; i++) seq = (seq << 4) | 256'h2;
    seq = (seq << 4) | 256'h4;
    chk_ops("nb34", seq, 39);
    chk_eq("nb34_op_count", op_count, 39);
    chk_eq("nb34_nreads", rd_addrs.size() - base_rd, 2);
    if (rd_addrs.size() > base_rd + 1) begin
      chk_eq("nb34_rd0_addr", rd_addrs[base_rd], 1);
      chk_eq("nb34_rd1_addr", rd_addrs[base_rd + 1], 0);
    end
    chk_eq("nb34_gap4", gap4 - base_gap4, 1);

    // Reset while waiting on the engine.
    mem[0] = 32'h0000_000B;
    repeat (8) @(negedge clk);
    exp_nbits = EBWL'(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_eq("wrst_busy", busy, 0);
    chk_eq("wrst_mp_start", mp_start, 0);
    chk_eq("wrst_op_count", op_count, 0);
    chk_eq("wrst_mp_op", mp_op, 0);
    repeat (4) @(negedge clk);
    chk_eq("wrst_idle_op_count", op_count, 0);

    mem[0] = 32'h0000_0001;
    run_exp("nb1", 1, 1'b0);
    chk_ops("nb1", 256'h01234, 5);
    chk_eq("nb1_op_count", op_count, 5);

    // Oversized length clamps to 4096 bits: first read is the top word.
    repeat (8) @(negedge clk);
    take_base();
    exp_nbits = EBWL'(8191);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && !exp_rd; i++) @(negedge clk);
    chk_eq("clamp_rd_seen", exp_rd, 1);
    chk_eq("clamp_rd_addr", exp_addr, 127);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_eq("clamp_rst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
